// File: rtl/seg_octal_decoder.sv
// Two-digit octal seven-segment readback decoder.
// Debounces the segment pins and recovers the one-hot code.
module seg_octal_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       seg_lo,
  input  logic [6:0]       seg_hi,
  output logic [15:0]      out_onehot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic             overrun,
  output logic [ERR_W-1:0] err_count
);

  localparam int CW =
    (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);
  localparam logic [13:0] BLANK = 14'h3FFF;

  logic [13:0] s_reg;
  logic [13:0] cand;
  logic [13:0] last;
  logic [CW-1:0] cnt;

  logic [6:0] xlo;
  logic [6:0] xhi;
  logic       lo_ok;
  logic       hi_ok;
  logic [2:0] lo_val;
  logic       hi_val;
  logic       blank;
  logic       legal;
  logic       fire;
  logic [15:0] dec;

  // Decode the candidate pattern; x is the lit-segment view.
  always_comb begin
    xlo    = ~cand[6:0];
    xhi    = ~cand[13:7];
    lo_ok  = 1'b1;
    lo_val = 3'd0;
    hi_ok  = 1'b1;
    hi_val = 1'b0;
    case (xlo)
      7'h7E: lo_val = 3'd0;
      7'h30: lo_val = 3'd1;
      7'h6D: lo_val = 3'd2;
      7'h79: lo_val = 3'd3;
      7'h33: lo_val = 3'd4;
      7'h5B: lo_val = 3'd5;
      7'h5F: lo_val = 3'd6;
      7'h70: lo_val = 3'd7;
      default: lo_ok = 1'b0;
    endcase
    case (xhi)
      7'h40: hi_val = 1'b0;
      7'h60: hi_val = 1'b1;
      default: hi_ok = 1'b0;
    endcase
    blank = (cand == BLANK);
    legal = lo_ok && hi_ok;
    dec   = 16'd1 << {hi_val, lo_val};
    fire  = (s_reg == cand) && (cnt == CMAX)
            && (cand != last);
  end

  // Sample pins and track how long the pattern has been stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg <= BLANK;
      cand  <= BLANK;
      last  <= BLANK;
      cnt   <= '0;
    end else begin
      s_reg <= {seg_hi, seg_lo};
      if (s_reg != cand) begin
        cand <= s_reg;
        cnt  <= '0;
      end else if (cnt != CMAX) begin
        cnt <= cnt + CW'(1);
      end
      if (fire) last <= cand;
    end
  end

  // Present decoded values, handshake, and flag errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_onehot <= '0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
      overrun    <= 1'b0;
      err_count  <= '0;
    end else begin
      err     <= 1'b0;
      overrun <= 1'b0;
      if (fire && !blank && legal) begin
        out_onehot <= dec;
        out_valid  <= 1'b1;
        overrun    <= out_valid && !out_ready;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (fire && !blank && !legal) begin
        err <= 1'b1;
        if (err_count != '1)
          err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg_octal_decoder.sv
// Bench for seg_octal_decoder.
// Random and directed stimulus against a history-based model.
module tb_seg_octal_decoder;

  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_lo;
  logic [6:0]  seg_hi;
  logic [15:0] out_onehot;
  logic        out_valid;
  logic        out_ready;
  logic        err;
  logic        overrun;
  logic [7:0]  err_count;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [13:0] hist[$];
  logic [13:0] mlast;
  logic        exp_valid;
  logic [15:0] exp_onehot;
  logic        exp_err;
  logic        exp_ovr;
  logic [7:0]  exp_cnt;

  logic [6:0] lo_tab[8] = '{7'h7E, 7'h30, 7'h6D, 7'h79,
                            7'h33, 7'h5B, 7'h5F, 7'h70};
  logic [6:0] hi_tab[2] = '{7'h40, 7'h60};

  logic [26:0] got;
  logic [26:0] exp_b;

  seg_octal_decoder #(.STABLE_CYCLES(SC), .ERR_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_lo(seg_lo),
    .seg_hi(seg_hi),
    .out_onehot(out_onehot),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err(err),
    .overrun(overrun),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // kind: 0 blank, 1 legal, 2 illegal
  task automatic classify(input logic [13:0] p,
                          output int kind, output int val);
    logic [6:0] xl;
    logic [6:0] xh;
    int li;
    int hi;
    xl = ~p[6:0];
    xh = ~p[13:7];
    li = -1;
    hi = -1;
    for (int i = 0; i < 8; i++) if (lo_tab[i] == xl) li = i;
    for (int i = 0; i < 2; i++) if (hi_tab[i] == xh) hi = i;
    val = 0;
    if (xl == 7'h0 && xh == 7'h0) kind = 0;
    else if (li >= 0 && hi >= 0) begin
      kind = 1;
      val = hi * 8 + li;
    end else kind = 2;
  endtask

  task automatic model_reset();
    hist.delete();
    mlast      = 14'h3FFF;
    exp_valid  = 1'b0;
    exp_onehot = '0;
    exp_err    = 1'b0;
    exp_ovr    = 1'b0;
    exp_cnt    = '0;
  endtask

  // A pattern fires once SC+1 identical captures precede an edge.
  task automatic model_edge();
    logic [13:0] v;
    logic evt;
    logic acc;
    int k;
    int vv;
    exp_err = 1'b0;
    exp_ovr = 1'b0;
    evt = 1'b0;
    k = 0;
    vv = 0;
    v = 14'h3FFF;
    if (hist.size() == SC + 1) begin
      evt = 1'b1;
      v = hist[0];
      foreach (hist[i]) if (hist[i] != v) evt = 1'b0;
      if (v == mlast) evt = 1'b0;
    end
    acc = exp_valid && out_ready;
    if (evt) begin
      mlast = v;
      classify(v, k, vv);
    end
    if (evt && k == 1) begin
      exp_ovr = exp_valid && !out_ready;
      exp_valid = 1'b1;
      exp_onehot = 16'd1 << vv;
    end else if (acc) begin
      exp_valid = 1'b0;
    end
    if (evt && k == 2) begin
      exp_err = 1'b1;
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    end
    hist.push_back({seg_hi, seg_lo});
    if (hist.size() > SC + 1) void'(hist.pop_front());
  endtask

  task automatic step(input logic [6:0] h,
                      input logic [6:0] l,
                      input logic r);
    seg_hi = h;
    seg_lo = l;
    out_ready = r;
    @(posedge clk);
    model_edge();
    #1;
    got   = {out_valid, out_onehot, err, overrun, err_count};
    exp_b = {exp_valid, exp_onehot, exp_err, exp_ovr, exp_cnt};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    seg_hi = 7'h7F;
    seg_lo = 7'h7F;
    out_ready = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({out_valid, out_onehot, err, overrun, err_count}
        !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_vals got=%h want=0",
               {out_valid, out_onehot, err, overrun, err_count});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(7'h7F, 7'h7F, 1'b0);
      n_tests++;
      if ({out_valid, err, overrun, err_count} !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got=%h want=0", i,
                 {out_valid, err, overrun, err_count});
      end
    end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 16; i++) begin
      step(7'h1F, 7'h06, 1'b0);
      n_tests++;
      if (got !== exp_b) begin
        n_fail++;
        $display("FAIL basic_hold cyc=%0d got=%h want=%h",
                 i, got, exp_b);
      end
      if (i == SC + 1) begin
        n_tests++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_early got=%b want=0", out_valid);
        end
      end
      if (i >= SC + 2) begin
        n_tests++;
        if ({out_valid, out_onehot} !== {1'b1, 16'h0800}) begin
          n_fail++;
          $display("FAIL basic_val cyc=%0d got=%b/%h want=1/0800",
                   i, out_valid, out_onehot);
        end
      end
    end
    step(7'h1F, 7'h06, 1'b1);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_accept got=%b want=0", out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      step(7'h1F, 7'h06, 1'b0);
      n_tests++;
      if (out_valid !== 1'b0 || got !== exp_b) begin
        n_fail++;
        $display("FAIL basic_noreevt got=%h want=%h", got, exp_b);
      end
    end
  endtask

  task automatic test_glitch();
    int seen;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      step(7'h3F, 7'h01, 1'b0);
      if (out_valid) seen++;
    end
    for (int i = 0; i < 8; i++) begin
      step(7'h7F, 7'h7F, 1'b0);
      if (out_valid) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL glitch_valid got=%0d want=0", seen);
    end
    for (int i = 1; i <= SC + 2; i++) begin
      step(7'h3F, 7'h01, 1'b0);
      n_tests++;
      if (got !== exp_b) begin
        n_fail++;
        $display("FAIL glitch_hold cyc=%0d got=%h want=%h",
                 i, got, exp_b);
      end
    end
    n_tests++;
    if ({out_valid, out_onehot} !== {1'b1, 16'h0001}) begin
      n_fail++;
      $display("FAIL glitch_val got=%b/%h want=1/0001",
               out_valid, out_onehot);
    end
  endtask

  task automatic test_illegal();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(7'h3F, 7'h00, 1'b1);
      if (err) pulses++;
      n_tests++;
      if (got !== exp_b) begin
        n_fail++;
        $display("FAIL illegal_hold got=%h want=%h", got, exp_b);
      end
    end
    n_tests++;
    if (pulses != 1 || err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL illegal_once got=%0d/%h want=1/01",
               pulses, err_count);
    end
    for (int r = 0; r < 299; r++) begin
      for (int i = 0; i < 6; i++) step(7'h7F, 7'h7F, 1'b1);
      for (int i = 0; i < 6; i++) step(7'h3F, 7'h00, 1'b1);
    end
    n_tests++;
    if (err_count !== 8'hFF || got !== exp_b) begin
      n_fail++;
      $display("FAIL illegal_sat got=%h want=ff", err_count);
    end
  endtask

  task automatic test_overrun();
    int pulses;
    for (int i = 0; i < 7; i++) step(7'h3F, 7'h4C, 1'b0);
    n_tests++;
    if ({out_valid, out_onehot} !== {1'b1, 16'h0010}) begin
      n_fail++;
      $display("FAIL ovr_first got=%b/%h want=1/0010",
               out_valid, out_onehot);
    end
    for (int i = 0; i < 7; i++) step(7'h7F, 7'h7F, 1'b0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(7'h1F, 7'h4C, 1'b0);
      if (overrun) pulses++;
      n_tests++;
      if (got !== exp_b) begin
        n_fail++;
        $display("FAIL ovr_hold got=%h want=%h", got, exp_b);
      end
    end
    n_tests++;
    if (pulses != 1 || out_onehot !== 16'h1000) begin
      n_fail++;
      $display("FAIL ovr_pulse got=%0d/%h want=1/1000",
               pulses, out_onehot);
    end
    for (int i = 0; i < 7; i++) step(7'h7F, 7'h7F, 1'b0);
    pulses = 0;
    for (int i = 1; i <= SC + 2; i++) begin
      step(7'h3F, 7'h4C, (i == SC + 2));
      if (overrun) pulses++;
    end
    n_tests++;
    if (pulses != 0 || {out_valid, out_onehot}
        !== {1'b1, 16'h0010}) begin
      n_fail++;
      $display("FAIL ovr_accload got=%0d/%b/%h want=0/1/0010",
               pulses, out_valid, out_onehot);
    end
  endtask

  task automatic test_random();
    logic [13:0] p;
    int v;
    int len;
    p = 14'h3FFF;
    for (int s = 0; s < 300; s++) begin
      case ($urandom_range(0, 5))
        0: p = 14'h3FFF;
        1, 2, 3: begin
          v = $urandom_range(0, 15);
          p = {~hi_tab[v / 8], ~lo_tab[v % 8]};
        end
        4: p = 14'($urandom);
        default: p = p;
      endcase
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        step(p[13:7], p[6:0], ($urandom_range(0, 3) == 0));
        n_tests++;
        if (got !== exp_b) begin
          n_fail++;
          $display("FAIL random seg=%0d got=%h want=%h",
                   s, got, exp_b);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) step(7'h7F, 7'h7F, 1'b0);
    for (int i = 0; i < 8; i++) step(7'h3F, 7'h00, 1'b0);
    for (int i = 0; i < 8; i++) step(7'h7F, 7'h7F, 1'b0);
    step(7'h1F, 7'h06, 1'b0);
    step(7'h1F, 7'h06, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({out_valid, out_onehot, err, overrun, err_count}
        !== 27'd0) begin
      n_fail++;
      $display("FAIL midrst_async got=%h want=0",
               {out_valid, out_onehot, err, overrun, err_count});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= SC + 3; i++) begin
      step(7'h1F, 7'h06, 1'b0);
      n_tests++;
      if (got !== exp_b) begin
        n_fail++;
        $display("FAIL midrst_hold cyc=%0d got=%h want=%h",
                 i, got, exp_b);
      end
      if (i == SC + 1 || i == SC + 2) begin
        n_tests++;
        if (out_valid !== (i == SC + 2)) begin
          n_fail++;
          $display("FAIL midrst_lat cyc=%0d got=%b want=%b",
                   i, out_valid, (i == SC + 2));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_illegal();
    test_overrun();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
